// File: rtl/frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_sched
// Brief    : Rotates 3/4 frame buffers between a writer and the axi2fifo reader.
// Revision : 1.0
// ============================================================================
module frame_buf_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BUF    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_run,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_buf_stride,
  input  logic [23:0]           cfg_timeout,
  input  logic                  frame_start,
  input  logic                  wr_frame_done,
  input  logic                  rd_sts_done,
  output logic                  rd_blk_en,
  output logic [ADDR_WIDTH-1:0] rd_map_ba,
  output logic [ADDR_WIDTH-1:0] wr_map_ba,
  output logic                  sts_busy,
  output logic                  sts_timeout,
  output logic [1:0]            sts_rd_idx,
  output logic [1:0]            sts_wr_idx,
  output logic [15:0]           sts_dropped,
  output logic [15:0]           sts_repeated
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic [15:0] c_cnt_max = 16'hFFFF;
  localparam logic [2:0]  c_num_buf = 3'(NUM_BUF);

  function automatic logic [1:0] f_wrap(input logic [2:0] x);
    f_wrap = (x >= c_num_buf) ? 2'(x - c_num_buf) : x[1:0];
  endfunction

  // base + idx*stride with idx limited to 2 bits: two conditional adds
  function automatic logic [ADDR_WIDTH-1:0] f_addr(
    input logic [1:0]            idx,
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] stride
  );
    logic [ADDR_WIDTH-1:0] a;
    a = base;
    if (idx[0]) a = a + stride;
    if (idx[1]) a = a + {stride[ADDR_WIDTH-2:0], 1'b0};
    f_addr = a;
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_hold_cnt, w_hold_cnt_nxt;
  logic [23:0]           r_wdog, w_wdog_nxt;
  logic                  r_run_q;
  logic [1:0]            r_rd_idx, w_rd_idx_nxt;
  logic [1:0]            r_wr_idx, w_wr_idx_nxt;
  logic [1:0]            r_latest_idx, w_latest_idx_nxt;
  logic                  r_fresh, w_fresh_nxt;
  logic                  r_have_frame, w_have_frame_nxt;
  logic                  r_blk_en, w_blk_en_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_ba, w_rd_ba_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ba, w_wr_ba_nxt;
  logic [15:0]           r_dropped, w_dropped_nxt;
  logic [15:0]           r_repeated, w_repeated_nxt;

  logic       w_rise;
  logic       w_start;
  logic       w_consume;
  logic [1:0] w_rd_sel;
  logic [1:0] w_wr_inc1;
  logic [1:0] w_wr_inc2;

  // pulses landing on the run rising edge are swallowed by the re-init
  assign w_rise    = cfg_run & ~r_run_q;
  assign w_start   = cfg_run & ~w_rise & (r_state == S_IDLE) & frame_start & r_have_frame;
  assign w_consume = w_start & r_fresh;
  assign w_rd_sel  = w_consume ? r_latest_idx : r_rd_idx;
  assign w_wr_inc1 = f_wrap({1'b0, r_wr_idx} + 3'd1);
  assign w_wr_inc2 = f_wrap({1'b0, r_wr_idx} + 3'd2);

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_wdog_nxt       = r_wdog;
    w_rd_idx_nxt     = r_rd_idx;
    w_wr_idx_nxt     = r_wr_idx;
    w_latest_idx_nxt = r_latest_idx;
    w_fresh_nxt      = r_fresh;
    w_have_frame_nxt = r_have_frame;
    w_blk_en_nxt     = r_blk_en;
    w_busy_nxt       = r_busy;
    w_timeout_nxt    = r_timeout;
    w_rd_ba_nxt      = r_rd_ba;
    w_dropped_nxt    = r_dropped;
    w_repeated_nxt   = r_repeated;

    if (!cfg_run) begin
      w_state_nxt  = S_IDLE;
      w_blk_en_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_rise) begin
      w_state_nxt      = S_IDLE;
      w_hold_cnt_nxt   = 1'b0;
      w_wdog_nxt       = '0;
      w_rd_idx_nxt     = 2'd0;
      w_wr_idx_nxt     = 2'd1;
      w_latest_idx_nxt = 2'd0;
      w_fresh_nxt      = 1'b0;
      w_have_frame_nxt = 1'b0;
      w_blk_en_nxt     = 1'b0;
      w_busy_nxt       = 1'b0;
      w_timeout_nxt    = 1'b0;
      w_dropped_nxt    = '0;
      w_repeated_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_nxt    = S_HOLD;
            w_hold_cnt_nxt = 1'b0;
            w_wdog_nxt     = 24'd1;
            w_blk_en_nxt   = 1'b1;
            w_busy_nxt     = 1'b1;
            w_rd_idx_nxt   = w_rd_sel;
            w_rd_ba_nxt    = f_addr(w_rd_sel, cfg_base, cfg_buf_stride);
            if (r_fresh) begin
              w_fresh_nxt = 1'b0;
            end else if (r_repeated != c_cnt_max) begin
              w_repeated_nxt = r_repeated + 16'd1;
            end
          end
        end
        S_HOLD: begin
          w_wdog_nxt = r_wdog + 24'd1;
          if (r_hold_cnt) begin
            w_state_nxt = S_BUSY;
          end else begin
            w_hold_cnt_nxt = 1'b1;
          end
        end
        S_BUSY: begin
          w_wdog_nxt = r_wdog + 24'd1;
          if (rd_sts_done) begin
            w_state_nxt  = S_IDLE;
            w_blk_en_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
          end else if ((cfg_timeout != 24'd0) && (r_wdog >= cfg_timeout)) begin
            w_state_nxt   = S_IDLE;
            w_blk_en_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_timeout_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_blk_en_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase

      // writer side sees the reader's buffer after this cycle's selection
      if (wr_frame_done) begin
        w_latest_idx_nxt = r_wr_idx;
        w_fresh_nxt      = 1'b1;
        w_have_frame_nxt = 1'b1;
        if (r_fresh && !w_consume && (r_dropped != c_cnt_max)) begin
          w_dropped_nxt = r_dropped + 16'd1;
        end
        w_wr_idx_nxt = (w_wr_inc1 == w_rd_sel) ? w_wr_inc2 : w_wr_inc1;
      end
    end

    w_wr_ba_nxt = f_addr(w_wr_idx_nxt, cfg_base, cfg_buf_stride);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= 1'b0;
      r_wdog       <= '0;
      r_run_q      <= 1'b0;
      r_rd_idx     <= 2'd0;
      r_wr_idx     <= 2'd1;
      r_latest_idx <= 2'd0;
      r_fresh      <= 1'b0;
      r_have_frame <= 1'b0;
      r_blk_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_rd_ba      <= '0;
      r_wr_ba      <= '0;
      r_dropped    <= '0;
      r_repeated   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_wdog       <= w_wdog_nxt;
      r_run_q      <= cfg_run;
      r_rd_idx     <= w_rd_idx_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_latest_idx <= w_latest_idx_nxt;
      r_fresh      <= w_fresh_nxt;
      r_have_frame <= w_have_frame_nxt;
      r_blk_en     <= w_blk_en_nxt;
      r_busy       <= w_busy_nxt;
      r_timeout    <= w_timeout_nxt;
      r_rd_ba      <= w_rd_ba_nxt;
      r_wr_ba      <= w_wr_ba_nxt;
      r_dropped    <= w_dropped_nxt;
      r_repeated   <= w_repeated_nxt;
    end
  end

  assign rd_blk_en    = r_blk_en;
  assign rd_map_ba    = r_rd_ba;
  assign wr_map_ba    = r_wr_ba;
  assign sts_busy     = r_busy;
  assign sts_timeout  = r_timeout;
  assign sts_rd_idx   = r_rd_idx;
  assign sts_wr_idx   = r_wr_idx;
  assign sts_dropped  = r_dropped;
  assign sts_repeated = r_repeated;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buf_sched
// Brief    : Directed plus randomized bench for frame_buf_sched with a model.
// Revision : 1.0
// ============================================================================
module tb_frame_buf_sched;

  localparam int NB = 3;
  localparam logic [31:0] c_base   = 32'h1000_0000;
  localparam logic [31:0] c_stride = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_run;
  logic [31:0] cfg_base;
  logic [31:0] cfg_buf_stride;
  logic [23:0] cfg_timeout;
  logic        frame_start;
  logic        wr_frame_done;
  logic        rd_sts_done;
  logic        rd_blk_en;
  logic [31:0] rd_map_ba;
  logic [31:0] wr_map_ba;
  logic        sts_busy;
  logic        sts_timeout;
  logic [1:0]  sts_rd_idx;
  logic [1:0]  sts_wr_idx;
  logic [15:0] sts_dropped;
  logic [15:0] sts_repeated;

  frame_buf_sched #(.ADDR_WIDTH(32), .NUM_BUF(NB)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_run(cfg_run), .cfg_base(cfg_base),
    .cfg_buf_stride(cfg_buf_stride), .cfg_timeout(cfg_timeout),
    .frame_start(frame_start), .wr_frame_done(wr_frame_done),
    .rd_sts_done(rd_sts_done), .rd_blk_en(rd_blk_en), .rd_map_ba(rd_map_ba),
    .wr_map_ba(wr_map_ba), .sts_busy(sts_busy), .sts_timeout(sts_timeout),
    .sts_rd_idx(sts_rd_idx), .sts_wr_idx(sts_wr_idx),
    .sts_dropped(sts_dropped), .sts_repeated(sts_repeated)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: reader occupancy is tracked as "cycles since start"
  int          m_rd = 0, m_wr = 1, m_latest = 0;
  bit          m_fresh = 0, m_have = 0, m_reading = 0, m_tmo = 0, m_run_q = 0;
  int          m_age = 0;
  int          m_drop = 0, m_rep = 0;
  logic [31:0] e_rd_ba = '0, e_wr_ba = '0;

  task automatic model_init();
    m_rd = 0; m_wr = 1; m_latest = 0; m_fresh = 0; m_have = 0;
    m_reading = 0; m_tmo = 0; m_drop = 0; m_rep = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit start, consumed, old_fresh, rise;
    int rd_new, c1;
    if (!rst_n) begin
      model_init();
      m_run_q = 0; e_rd_ba = '0; e_wr_ba = '0;
      return;
    end
    rise = cfg_run && !m_run_q;
    m_run_q = cfg_run;
    if (!cfg_run) begin
      m_reading = 0;
    end else if (rise) begin
      model_init();
    end else begin
      start     = !m_reading && frame_start && m_have;
      consumed  = start && m_fresh;
      rd_new    = consumed ? m_latest : m_rd;
      old_fresh = m_fresh;
      if (m_reading) begin
        if (m_age >= 3 && rd_sts_done) m_reading = 0;
        else if (m_age >= 3 && cfg_timeout != 0 && m_age == int'(cfg_timeout)) begin
          m_reading = 0; m_tmo = 1;
        end else m_age++;
      end
      if (start) begin
        m_reading = 1; m_age = 1; m_rd = rd_new;
        e_rd_ba = cfg_base + 32'(rd_new) * cfg_buf_stride;
        if (consumed) m_fresh = 0;
        else if (m_rep < 65535) m_rep++;
      end
      if (wr_frame_done) begin
        if (old_fresh && !consumed && m_drop < 65535) m_drop++;
        m_latest = m_wr; m_fresh = 1; m_have = 1;
        c1 = (m_wr + 1) % NB;
        m_wr = (c1 == rd_new) ? (m_wr + 2) % NB : c1;
      end
    end
    e_wr_ba = cfg_base + 32'(m_wr) * cfg_buf_stride;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("blk_en",   {31'd0, rd_blk_en},   {31'd0, m_reading});
      check("busy",     {31'd0, sts_busy},    {31'd0, m_reading});
      check("timeout",  {31'd0, sts_timeout}, {31'd0, m_tmo});
      check("rd_ba",    rd_map_ba, e_rd_ba);
      check("wr_ba",    wr_map_ba, e_wr_ba);
      check("rd_idx",   {30'd0, sts_rd_idx}, 32'(m_rd));
      check("wr_idx",   {30'd0, sts_wr_idx}, 32'(m_wr));
      check("dropped",  {16'd0, sts_dropped},  32'(m_drop));
      check("repeated", {16'd0, sts_repeated}, 32'(m_rep));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_run();
    cfg_run = 1'b0; step();
    cfg_run = 1'b1; step();
  endtask

  // done sampled on the first BUSY cycle, three edges after the start edge
  task automatic finish_read();
    repeat (2) step();
    rd_sts_done = 1'b1; step();
    rd_sts_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_run = 1'b0; cfg_base = '0; cfg_buf_stride = '0;
    cfg_timeout = '0; frame_start = 1'b0; wr_frame_done = 1'b0; rd_sts_done = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    check("rst_blk_en", {31'd0, rd_blk_en}, 32'd0);
    check("rst_wr_idx", {30'd0, sts_wr_idx}, 32'd1);
    check("rst_wr_ba",  wr_map_ba, 32'd0);

    rst_n = 1'b1; cfg_run = 1'b1; cfg_base = c_base; cfg_buf_stride = c_stride;
    step(); step();
    check("wr_ba_init", wr_map_ba, 32'h1010_0000);

    frame_start = 1'b1; step(); frame_start = 1'b0; step();
    check("no_frame_blk", {31'd0, rd_blk_en}, 32'd0);
    check("no_frame_rep", {16'd0, sts_repeated}, 32'd0);

    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    check("wr_ba_after_done", wr_map_ba, 32'h1020_0000);
    check("wr_idx_after_done", {30'd0, sts_wr_idx}, 32'd2);

    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("first_blk_en", {31'd0, rd_blk_en}, 32'd1);
    check("first_rd_ba", rd_map_ba, 32'h1010_0000);
    rd_sts_done = 1'b1; step(); step();
    check("hold_ignores_done", {31'd0, rd_blk_en}, 32'd1);
    rd_sts_done = 1'b0; step(); step();
    rd_sts_done = 1'b1; step(); rd_sts_done = 1'b0;
    check("done_drops_blk", {31'd0, rd_blk_en}, 32'd0);

    toggle_run();
    repeat (3) begin
      wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0; step();
    end
    check("dropped_2", {16'd0, sts_dropped}, 32'd2);
    check("wr_idx_skip", {30'd0, sts_wr_idx}, 32'd2);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("latest_rd_ba", rd_map_ba, 32'h1010_0000);
    check("latest_rd_idx", {30'd0, sts_rd_idx}, 32'd1);
    finish_read();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("repeat_rd_ba", rd_map_ba, 32'h1010_0000);
    check("repeat_cnt", {16'd0, sts_repeated}, 32'd1);
    finish_read();

    cfg_timeout = 24'd100;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (99) step();
    check("wdog_before", {31'd0, rd_blk_en}, 32'd1);
    step();
    check("wdog_fire_blk", {31'd0, rd_blk_en}, 32'd0);
    check("wdog_fire_sts", {31'd0, sts_timeout}, 32'd1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    finish_read();
    check("timeout_sticky", {31'd0, sts_timeout}, 32'd1);
    cfg_timeout = 24'd0;
    toggle_run();
    check("timeout_cleared", {31'd0, sts_timeout}, 32'd0);

    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    wr_frame_done = 1'b1; step();
    frame_start = 1'b1; step(); frame_start = 1'b0; wr_frame_done = 1'b0;
    check("simul_rd_ba", rd_map_ba, 32'h1020_0000);
    check("simul_wr_idx", {30'd0, sts_wr_idx}, 32'd0);
    check("simul_wr_ba", wr_map_ba, 32'h1000_0000);
    check("simul_dropped", {16'd0, sts_dropped}, 32'd1);
    finish_read();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("simul_fresh_kept", rd_map_ba, 32'h1010_0000);
    check("simul_no_repeat", {16'd0, sts_repeated}, 32'd0);

    step();
    rst_n = 1'b0; #1;
    check("async_rst_blk", {31'd0, rd_blk_en}, 32'd0);
    step(); rst_n = 1'b1; step();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cfg_run = 1'b0;
        cfg_base = $urandom;
        cfg_buf_stride = $urandom;
        cfg_timeout = ($urandom_range(0, 2) == 0) ? 24'd0 : 24'($urandom_range(3, 40));
      end else begin
        cfg_run = 1'b1;
      end
      frame_start   = ($urandom_range(0, 3) == 0);
      wr_frame_done = ($urandom_range(0, 3) == 0);
      rd_sts_done   = ($urandom_range(0, 7) == 0);
      step();
    end
    frame_start = 1'b0; wr_frame_done = 1'b0; rd_sts_done = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buf_sched.md
# frame_buf_sched

Frame-level scheduler that sequences the AXI frame reader (axi2fifo) and rotates 3 or 4 frame buffers in memory between an external frame writer and that reader. On each display frame request it picks the newest completed buffer, loads its base address into the reader, and pulses the reader enable. It then waits for the reader's done status, with a watchdog. It sits between the register block and the reader's configuration port, and tracks dropped and repeated frames.

## Interface
- ADDR_WIDTH, 32, address width of buffer bases
- NUM_BUF, 3, number of frame buffers; legal values 3 or 4
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cfg_run  in  1  scheduler enable (level)
- cfg_base  in  ADDR_WIDTH  base address of buffer 0
- cfg_buf_stride  in  ADDR_WIDTH  byte distance between consecutive buffers
- cfg_timeout  in  24  watchdog limit in cycles; 0 disables watchdog
- frame_start  in  1  one-cycle pulse: display needs the next frame
- wr_frame_done  in  1  one-cycle pulse: writer finished the buffer at wr_map_ba
- rd_sts_done  in  1  reader done status (axi2fifo sts_done)
- rd_blk_en  out  1  reader block enable (drives axi2fifo cfg_blk_en)
- rd_map_ba  out  ADDR_WIDTH  reader buffer base (drives axi2fifo cfg_map_ba)
- wr_map_ba  out  ADDR_WIDTH  base of the buffer the writer must fill next
- sts_busy  out  1  high while a frame read is in flight
- sts_timeout  out  1  sticky: watchdog fired
- sts_rd_idx  out  2  buffer index currently owned by the reader
- sts_wr_idx  out  2  buffer index currently owned by the writer
- sts_dropped  out  16  completed frames overwritten before being read, saturating
- sts_repeated  out  16  frame requests served by repeating the previous buffer, saturating

## Operation
- Internal state:
  - rd_idx, wr_idx, latest_idx (2 bits each)
  - fresh: latest is complete and unread
  - have_frame: at least one completion since run start
- Reset and cfg_run rising edge both apply the same values:
  - rd_idx=0, wr_idx=1, latest_idx=0, fresh=0, have_frame=0.
  - Both counters and sts_timeout clear.
- FSM states: IDLE, HOLD, BUSY.
  - IDLE to HOLD: cfg_run & frame_start & have_frame.
    - If fresh: rd_idx<=latest_idx and fresh<=0.
    - Otherwise keep rd_idx and increment sts_repeated.
    - Set rd_blk_en<=1 and clear the watchdog.
  - frame_start in IDLE with have_frame=0 is ignored; no counter changes.
  - HOLD lasts 2 cycles. rd_sts_done is ignored here because the reader's done flag is stale until its start edge clears it. HOLD then goes to BUSY.
  - BUSY to IDLE on rd_sts_done: rd_blk_en<=0.
  - BUSY to IDLE when the watchdog count equals cfg_timeout (cfg_timeout≠0): rd_blk_en<=0, sts_timeout<=1.
  - frame_start outside IDLE is ignored.
- Writer rotation on wr_frame_done (any state, cfg_run=1):
  - latest_idx<=wr_idx, fresh<=1, have_frame<=1.
  - If fresh was 1 and not consumed in the same cycle, sts_dropped increments.
  - wr_idx<=(wr_idx+1) mod NUM_BUF. If that equals the reader's buffer, use (wr_idx+2) mod NUM_BUF instead.
  - The reader's buffer here is the new rd_idx when a start is selected in the same cycle. The writer never receives rd_idx.
- Simultaneous frame_start and wr_frame_done: the start uses the pre-update latest_idx/fresh. The new completion stays fresh.
- Address arithmetic: base = cfg_base + idx*cfg_buf_stride, computed with shift-add, modulo 2^ADDR_WIDTH.
- cfg_run low: go to IDLE immediately, rd_blk_en<=0, ignore all pulses. Index registers hold until the next rising edge re-initialises them.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - rd_blk_en=0, rd_map_ba=0, wr_map_ba=0, sts_busy=0, sts_timeout=0.
  - sts_rd_idx=0, sts_wr_idx=1, counters=0.
  - FSM in IDLE.
- All outputs are registered.
- frame_start accepted at cycle T gives rd_map_ba valid and rd_blk_en=1 at T+1, on the same edge.
- sts_busy is high from T+1 until rd_blk_en falls.
- rd_sts_done is first sampled at T+3.
- rd_sts_done sampled at D gives rd_blk_en=0 at D+1. The earliest next frame_start is at D+1, giving rd_blk_en=1 at D+2, so the low gap is at least 1 cycle, which the reader needs to see a rising edge.
- Watchdog counts cycles in HOLD and BUSY from T+1. It fires when the count equals cfg_timeout.
- wr_frame_done at W gives the new wr_map_ba and sts_wr_idx at W+1.
- A reset asserted mid-frame drops rd_blk_en asynchronously.

## Test plan
- Reset, then cfg_run=1, cfg_base=0x1000_0000, cfg_buf_stride=0x0010_0000, and frame_start before any wr_frame_done -> rd_blk_en stays 0 and sts_repeated=0.
- wr_frame_done, then frame_start at T -> at T+1 rd_blk_en=1 and rd_map_ba=0x1010_0000 (buffer 1). wr_map_ba=0x1020_0000 one cycle after the wr_frame_done. rd_sts_done held high at T+1..T+2 is ignored; rd_sts_done at T+5 gives rd_blk_en=0 at T+6.
- Three wr_frame_done pulses with no frame_start (NUM_BUF=3) -> sts_dropped=2, wr_idx never equals rd_idx (0), and the next read selects the latest index.
- Two frame_start requests with no new write -> second read repeats the same rd_map_ba and sts_repeated=1.
- cfg_timeout=100, rd_sts_done never asserted -> rd_blk_en falls at T+101 and sts_timeout=1 and stays 1 until cfg_run is toggled.
- frame_start and wr_frame_done in the same cycle with fresh=1 -> reader takes the old latest, the new buffer stays fresh, sts_dropped is unchanged, and wr_idx skips the new rd_idx.
